// File: rtl/lm32_mmu_pkg.sv
// Shared MMU definitions: TLB FSM encoding, TLB entry flag positions and
// tlbpaddr flag bit positions.
`ifndef LM32_MMU_PKG_SV
`define LM32_MMU_PKG_SV

// Low flag bits of a stored TLB entry; tag and pfn are packed above them.
`define LM32_TLBE_VALID_BIT     0
`define LM32_TLBE_WRITABLE_BIT  1
`define LM32_TLBE_FLAGS_W       2
`define LM32_TLBE_GLOBAL_BIT    2
`define LM32_TLBE_ASID_LSB      3

package lm32_mmu_pkg;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    INVAL = 2'd1,
    FLUSH = 2'd2
  } tlb_state_e;

  localparam int TLBPADDR_WRITABLE_BIT = 1;
  localparam int TLBPADDR_GLOBAL_BIT   = 0;

endpackage

`endif

// File: rtl/lm32_ram.sv
// Simple dual-read, single-write RAM with registered read ports; a read of
// the address being written in the same cycle returns the old contents.
module lm32_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_a_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (re_a_i) begin
        rdata_a_q <= mem[raddr_a_i];
      end
      rdata_b_q <= mem[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/lm32_tlb_way.sv
// One TLB way: entry RAM plus lookup and CSR-side tag compare.
// Entry layout depends on LM32_DTLB_ASID_EN (adds global bit and asid field).
module lm32_tlb_way #(
  parameter int IDX_W  = 7,
  parameter int TAG_W  = 13,
  parameter int PFN_W  = 20,
  parameter int ASID_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic [IDX_W-1:0]  csr_idx_i,
  input  logic [TAG_W-1:0]  csr_tag_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [PFN_W-1:0]  wr_pfn_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              wr_writable_i,
  input  logic              wr_global_i,
  input  logic              wr_valid_i,
  output logic              hit_o,
  output logic [PFN_W-1:0]  pfn_o,
  output logic              writable_o,
  output logic              csr_match_o
);

`ifdef LM32_DTLB_ASID_EN
  localparam int META_W = `LM32_TLBE_ASID_LSB + ASID_W;
`else
  localparam int META_W = `LM32_TLBE_FLAGS_W;
`endif
  localparam int TAG_LSB = META_W;
  localparam int PFN_LSB = TAG_LSB + TAG_W;
  localparam int ENTRY_W = PFN_LSB + PFN_W;

  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rd_entry;
  logic [ENTRY_W-1:0] csr_entry;
  logic               asid_ok;
  logic               unused_csr;

  always_comb begin
    wdata                               = '0;
    wdata[`LM32_TLBE_VALID_BIT]         = wr_valid_i;
    wdata[`LM32_TLBE_WRITABLE_BIT]      = wr_writable_i;
    wdata[TAG_LSB +: TAG_W]             = wr_tag_i;
    wdata[PFN_LSB +: PFN_W]             = wr_pfn_i;
`ifdef LM32_DTLB_ASID_EN
    wdata[`LM32_TLBE_GLOBAL_BIT]        = wr_global_i;
    wdata[`LM32_TLBE_ASID_LSB +: ASID_W] = asid_i;
`endif
  end

  lm32_ram #(
    .DATA_W (ENTRY_W),
    .ADDR_W (IDX_W)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (we_i),
    .waddr_i   (wr_idx_i),
    .wdata_i   (wdata),
    .re_a_i    (re_i),
    .raddr_a_i (rd_idx_i),
    .rdata_a_o (rd_entry),
    .raddr_b_i (csr_idx_i),
    .rdata_b_o (csr_entry)
  );

`ifdef LM32_DTLB_ASID_EN
  assign asid_ok = rd_entry[`LM32_TLBE_GLOBAL_BIT] |
                   (rd_entry[`LM32_TLBE_ASID_LSB +: ASID_W] == asid_i);
`else
  logic unused_asid;
  assign unused_asid = ^{asid_i, wr_global_i};
  assign asid_ok     = 1'b1;
`endif

  assign hit_o       = rd_entry[`LM32_TLBE_VALID_BIT] &
                       (rd_entry[TAG_LSB +: TAG_W] == rd_tag_i) & asid_ok;
  assign pfn_o       = rd_entry[PFN_LSB +: PFN_W];
  assign writable_o  = rd_entry[`LM32_TLBE_WRITABLE_BIT];
  assign csr_match_o = csr_entry[`LM32_TLBE_VALID_BIT] &
                       (csr_entry[TAG_LSB +: TAG_W] == csr_tag_i);
  assign unused_csr  = ^csr_entry;

endmodule

// File: rtl/lm32_dtlb_assoc.sv
// Set-associative LM32 data TLB with round-robin refill, write protection and
// flush-by-walk. Optional ASID matching is enabled with LM32_DTLB_ASID_EN.
import lm32_mmu_pkg::*;

module lm32_dtlb_assoc #(
  parameter int entries    = 256,
  parameter int ways       = 2,
  parameter int page_size  = 4096,
  parameter int asid_width = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable,
  input  logic                  stall_x,
  input  logic                  stall_m,
  input  logic                  load_d,
  input  logic                  store_d,
  input  logic                  load_q_x,
  input  logic                  store_q_x,
  input  logic [31:0]           address_x,
  input  logic [31:0]           address_m,
  input  logic [asid_width-1:0] asid,
  input  logic [31:0]           tlbvaddr,
  input  logic [31:0]           tlbpaddr,
  input  logic                  update,
  input  logic                  invalidate,
  input  logic                  flush,
  output logic [31:0]           physical_load_store_address_m,
  output logic                  stall_request,
  output logic                  miss,
  output logic                  fault
);

  localparam int SETS  = entries / ways;
  localparam int OFF_W = $clog2(page_size);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W;
  localparam int PFN_W = 32 - OFF_W;
  localparam int WAY_W = (ways > 1) ? $clog2(ways) : 1;

  tlb_state_e       state_q, state_d;
  logic [IDX_W-1:0] flush_set_q, flush_set_d;
  logic [WAY_W-1:0] rr_way_q, rr_way_d;
  logic             lookup_q, lookup_d;
  logic [PFN_W-1:0] tlbe_pfn_m_q, tlbe_pfn_m_d;
  logic [IDX_W-1:0] inval_idx_q, inval_idx_d;
  logic [TAG_W-1:0] inval_tag_q, inval_tag_d;

  logic [ways-1:0]  hit_way;
  logic [ways-1:0]  csr_match;
  logic [ways-1:0]  way_we;
  logic [ways-1:0]  way_writable;
  logic [PFN_W-1:0] way_pfn [ways];
  logic [IDX_W-1:0] csr_idx;
  logic [TAG_W-1:0] tlb_tag;
  logic [TAG_W-1:0] csr_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [PFN_W-1:0] wr_pfn;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_writable;
  logic             wr_global;
  logic             wr_valid;
  logic [PFN_W-1:0] hit_pfn;
  logic             hit_writable;
  logic             unused_bits;

  assign csr_idx = tlbvaddr[OFF_W +: IDX_W];
  assign tlb_tag = tlbvaddr[31 -: TAG_W];
  // INVAL compares against the address captured when the invalidate was taken.
  assign csr_tag = (state_q == INVAL) ? inval_tag_q : tlb_tag;
  assign unused_bits = ^{address_x[OFF_W-1:0], tlbvaddr[OFF_W-1:0], tlbpaddr[OFF_W-1:2]};

  for (genvar w = 0; w < ways; w++) begin : g_way
    lm32_tlb_way #(
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .PFN_W  (PFN_W),
      .ASID_W (asid_width)
    ) u_way (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .re_i          (lookup_q),
      .rd_idx_i      (address_x[OFF_W +: IDX_W]),
      .rd_tag_i      (address_x[31 -: TAG_W]),
      .asid_i        (asid),
      .csr_idx_i     (csr_idx),
      .csr_tag_i     (csr_tag),
      .we_i          (way_we[w]),
      .wr_idx_i      (wr_idx),
      .wr_pfn_i      (wr_pfn),
      .wr_tag_i      (wr_tag),
      .wr_writable_i (wr_writable),
      .wr_global_i   (wr_global),
      .wr_valid_i    (wr_valid),
      .hit_o         (hit_way[w]),
      .pfn_o         (way_pfn[w]),
      .writable_o    (way_writable[w]),
      .csr_match_o   (csr_match[w])
    );
  end

  // Lowest-index hitting way wins.
  always_comb begin
    hit_pfn      = '0;
    hit_writable = 1'b0;
    for (int w = ways - 1; w >= 0; w--) begin
      hit_pfn      = hit_way[w] ? way_pfn[w] : hit_pfn;
      hit_writable = hit_way[w] ? way_writable[w] : hit_writable;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_set_d = flush_set_q;
    rr_way_d    = rr_way_q;
    inval_idx_d = inval_idx_q;
    inval_tag_d = inval_tag_q;
    way_we      = '0;
    wr_idx      = csr_idx;
    wr_pfn      = '0;
    wr_tag      = '0;
    wr_writable = 1'b0;
    wr_global   = 1'b0;
    wr_valid    = 1'b0;
    case (state_q)
      CHECK: begin
        if (flush) begin
          flush_set_d = '1;
          state_d     = FLUSH;
        end else if (invalidate) begin
          inval_idx_d = csr_idx;
          inval_tag_d = tlb_tag;
          state_d     = INVAL;
        end else if (update) begin
          wr_pfn      = tlbpaddr[31:OFF_W];
          wr_tag      = tlb_tag;
          wr_writable = tlbpaddr[TLBPADDR_WRITABLE_BIT];
          wr_global   = tlbpaddr[TLBPADDR_GLOBAL_BIT];
          wr_valid    = 1'b1;
          // Re-mapping a resident page overwrites it instead of duplicating it.
          if (|csr_match) begin
            way_we = csr_match & (~csr_match + ways'(1));
          end else begin
            for (int w = 0; w < ways; w++) begin
              way_we[w] = (rr_way_q == WAY_W'(w));
            end
            rr_way_d = (rr_way_q == WAY_W'(ways - 1)) ? '0 : rr_way_q + WAY_W'(1);
          end
        end else begin
          state_d = CHECK;
        end
      end
      INVAL: begin
        wr_idx  = inval_idx_q;
        way_we  = csr_match;
        state_d = CHECK;
      end
      FLUSH: begin
        wr_idx = flush_set_q;
        way_we = '1;
        if (flush_set_q == '0) begin
          state_d = CHECK;
        end else begin
          flush_set_d = flush_set_q - IDX_W'(1);
        end
      end
      default: state_d = CHECK;
    endcase
  end

  assign lookup_d     = enable & ~stall_x & (load_d | store_d);
  assign tlbe_pfn_m_d = stall_m ? tlbe_pfn_m_q : hit_pfn;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FLUSH;
      flush_set_q  <= '1;
      rr_way_q     <= '0;
      lookup_q     <= 1'b0;
      tlbe_pfn_m_q <= '0;
      inval_idx_q  <= '0;
      inval_tag_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_set_q  <= flush_set_d;
      rr_way_q     <= rr_way_d;
      lookup_q     <= lookup_d;
      tlbe_pfn_m_q <= tlbe_pfn_m_d;
      inval_idx_q  <= inval_idx_d;
      inval_tag_q  <= inval_tag_d;
    end
  end

  assign stall_request = (state_q == FLUSH) | lookup_q;
  assign miss  = enable & (load_q_x | store_q_x) & ~(|hit_way) & ~lookup_q;
  assign fault = enable & store_q_x & (|hit_way) & ~hit_writable & ~lookup_q;
  assign physical_load_store_address_m = enable ? {tlbe_pfn_m_q, address_m[OFF_W-1:0]}
                                                : address_m;

endmodule

// File: tb/tb_lm32_dtlb_assoc.sv
// Directed self-checking bench for lm32_dtlb_assoc (default geometry:
// 256 entries, 2 ways, 4 KiB pages -> index = vaddr[18:12], tag = vaddr[31:19]).
module tb_lm32_dtlb_assoc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable, stall_x, stall_m;
  logic        load_d, store_d, load_q_x, store_q_x;
  logic [31:0] address_x, address_m;
  logic [7:0]  asid;
  logic [31:0] tlbvaddr, tlbpaddr;
  logic        update, invalidate, flush;
  logic [31:0] physical_load_store_address_m;
  logic        stall_request, miss, fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  lm32_dtlb_assoc dut (
    .clk_i                         (clk_i),
    .rst_i                         (rst_i),
    .enable                        (enable),
    .stall_x                       (stall_x),
    .stall_m                       (stall_m),
    .load_d                        (load_d),
    .store_d                       (store_d),
    .load_q_x                      (load_q_x),
    .store_q_x                     (store_q_x),
    .address_x                     (address_x),
    .address_m                     (address_m),
    .asid                          (asid),
    .tlbvaddr                      (tlbvaddr),
    .tlbpaddr                      (tlbpaddr),
    .update                        (update),
    .invalidate                    (invalidate),
    .flush                         (flush),
    .physical_load_store_address_m (physical_load_store_address_m),
    .stall_request                 (stall_request),
    .miss                          (miss),
    .fault                         (fault)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // D-stage request, X-stage address, then sample miss/fault and the M-stage address.
  task automatic access(input logic [31:0] a, input logic st,
                        output logic m, output logic f, output logic [31:0] pa);
    @(negedge clk_i);
    enable = 1'b1; stall_m = 1'b0; load_d = ~st; store_d = st;
    @(negedge clk_i);
    load_d = 1'b0; store_d = 1'b0; load_q_x = ~st; store_q_x = st;
    address_x = a; address_m = a;
    @(negedge clk_i); #1;
    m = miss; f = fault;
    @(negedge clk_i); #1;
    pa = physical_load_store_address_m;
    load_q_x = 1'b0; store_q_x = 1'b0;
  endtask

  task automatic csr_write(input logic [31:0] v, input logic [31:0] p,
                           input logic upd, input logic inv);
    @(negedge clk_i);
    tlbvaddr = v; tlbpaddr = p;
    @(negedge clk_i);
    update = upd; invalidate = inv;
    @(negedge clk_i);
    update = 1'b0; invalidate = 1'b0;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (stall_request === 1'b1 && n < 1000) begin
      @(negedge clk_i); #1;
      n++;
    end
  endtask

  initial begin
    logic        m, f;
    logic [31:0] pa;
    int          n;

    rst_i = 1'b1; enable = 1'b0; stall_x = 1'b0; stall_m = 1'b0;
    load_d = 1'b0; store_d = 1'b0; load_q_x = 1'b0; store_q_x = 1'b0;
    address_x = 32'h0; address_m = 32'h0; asid = 8'd0;
    tlbvaddr = 32'h0; tlbpaddr = 32'h0;
    update = 1'b0; invalidate = 1'b0; flush = 1'b0;

    repeat (3) @(negedge clk_i);
    #1;
    check_val("rst_stall", {31'd0, stall_request}, 32'd1);
    check_val("rst_miss",  {31'd0, miss},          32'd0);
    check_val("rst_fault", {31'd0, fault},         32'd0);

    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    count_stall(n);
    check_val("rst_flush_cycles", n, 32'd128);

    access(32'h0000_1000, 1'b0, m, f, pa);
    check_val("empty_miss",  {31'd0, m}, 32'd1);
    check_val("empty_fault", {31'd0, f}, 32'd0);

    csr_write(32'h0000_5000, 32'h1234_5002, 1'b1, 1'b0);
    access(32'h0000_5ABC, 1'b0, m, f, pa);
    check_val("upd_miss", {31'd0, m}, 32'd0);
    check_val("upd_pa",   pa,         32'h1234_5ABC);

    // Set 5: rewrite resident page, then two new pages; the second evicts way 0.
    csr_write(32'h0000_5000, 32'h1234_5002, 1'b1, 1'b0);
    csr_write(32'h0008_5000, 32'h2222_2002, 1'b1, 1'b0);
    csr_write(32'h0010_5000, 32'h3333_3002, 1'b1, 1'b0);
    access(32'h0000_5000, 1'b0, m, f, pa);
    check_val("rr_evicted_miss", {31'd0, m}, 32'd1);
    access(32'h0008_5000, 1'b0, m, f, pa);
    check_val("rr_way1_miss", {31'd0, m}, 32'd0);
    check_val("rr_way1_pa",   pa,         32'h2222_2000);
    access(32'h0010_5010, 1'b0, m, f, pa);
    check_val("rr_way0_miss", {31'd0, m}, 32'd0);
    check_val("rr_way0_pa",   pa,         32'h3333_3010);

    csr_write(32'h0000_7000, 32'h4444_4000, 1'b1, 1'b0);
    access(32'h0000_7004, 1'b1, m, f, pa);
    check_val("ro_store_fault", {31'd0, f}, 32'd1);
    check_val("ro_store_miss",  {31'd0, m}, 32'd0);
    access(32'h0000_7004, 1'b0, m, f, pa);
    check_val("ro_load_fault", {31'd0, f}, 32'd0);
    check_val("ro_load_pa",    pa,         32'h4444_4004);
    access(32'h0008_5008, 1'b1, m, f, pa);
    check_val("rw_store_fault", {31'd0, f}, 32'd0);
    check_val("rw_store_miss",  {31'd0, m}, 32'd0);

    csr_write(32'h0000_5000, 32'h5555_5002, 1'b1, 1'b0);
    access(32'h0000_5000, 1'b0, m, f, pa);
    check_val("reload_pa", pa, 32'h5555_5000);

    csr_write(32'h0000_5000, 32'h6666_6002, 1'b1, 1'b1);
    access(32'h0000_5000, 1'b0, m, f, pa);
    check_val("inval_wins_miss", {31'd0, m}, 32'd1);
    access(32'h0008_5000, 1'b0, m, f, pa);
    check_val("inval_other_miss", {31'd0, m}, 32'd0);
    check_val("inval_other_pa",   pa,         32'h2222_2000);

    @(negedge clk_i);
    flush = 1'b1;
    #1;
    check_val("pre_flush_stall", {31'd0, stall_request}, 32'd0);
    @(negedge clk_i);
    flush = 1'b0;
    #1;
    count_stall(n);
    check_val("flush_cycles", n, 32'd128);
    access(32'h0008_5000, 1'b0, m, f, pa);
    check_val("post_flush_miss", {31'd0, m}, 32'd1);

    @(negedge clk_i);
    enable = 1'b0; load_q_x = 1'b1;
    address_x = 32'hDEAD_BEEF; address_m = 32'hDEAD_BEEF;
    #1;
    check_val("ident_pa",   physical_load_store_address_m, 32'hDEAD_BEEF);
    check_val("ident_miss", {31'd0, miss},                 32'd0);
    load_q_x = 1'b0;

`ifdef LM32_DTLB_ASID_EN
    asid = 8'd3;
    csr_write(32'h0000_9000, 32'h7777_7002, 1'b1, 1'b0);
    asid = 8'd4;
    access(32'h0000_9000, 1'b0, m, f, pa);
    check_val("asid_other_miss", {31'd0, m}, 32'd1);
    asid = 8'd3;
    csr_write(32'h0000_9000, 32'h7777_7003, 1'b1, 1'b0);
    asid = 8'd4;
    access(32'h0000_9000, 1'b0, m, f, pa);
    check_val("asid_global_miss", {31'd0, m}, 32'd0);
    check_val("asid_global_pa",   pa,         32'h7777_7000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
